// File: rtl/obi_subordinate_mem_if.sv
// OBI A/R channel bundle between a master and obi_subordinate_mem.
interface obi_subordinate_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int BW = DATA_WIDTH / 8;

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BW-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, addr, we, be, wdata, rready,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, addr, we, be, wdata, rready,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_subordinate_mem.sv
// OBI subordinate backed by a register-file memory with an in-order response FIFO.
// Optional macro OBI_SBR_BE_EN enables byte-lane write masking.
module obi_subordinate_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16,
  parameter int GNT_WAIT   = 0,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  obi_subordinate_mem_if.slave bus,
  output logic [7:0]           err_cnt_o
);
  localparam int BW   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BW);
  localparam int AW   = $clog2(NUM_WORDS);
  localparam int CW   = $clog2(RSP_DEPTH + 1);
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_mem;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] r_fdata;
  logic [RSP_DEPTH-1:0]                 r_ferr;
  logic [PW-1:0]                        r_wptr, r_rptr;
  logic [CW-1:0]                        r_count;
  logic [3:0]                           r_wait_cnt;
  logic [7:0]                           r_err_cnt;

  logic                  w_gnt, w_acc, w_pop, w_aligned, w_hit;
  logic [AW-1:0]         w_idx;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [BW-1:0]         w_be_eff;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_gnt = bus.req && (r_wait_cnt == 4'(GNT_WAIT)) && (r_count < CW'(RSP_DEPTH));
  assign w_acc = bus.req && w_gnt;
  assign w_pop = bus.rvalid && bus.rready;

  assign w_aligned = (bus.addr[OFFW-1:0] == '0);
  assign w_word    = bus.addr >> OFFW;
  assign w_idx     = w_word[AW-1:0];
  assign w_hit     = w_aligned && (w_word < ADDR_WIDTH'(NUM_WORDS));

`ifdef OBI_SBR_BE_EN
  assign w_be_eff = bus.be;
`else
  // be is ignored in this build: every write hit updates the full word
  assign w_be_eff = bus.be | {BW{1'b1}};
`endif

  assign w_push_data = (w_hit && !bus.we) ? r_mem[w_idx] : '0;

  assign bus.gnt    = w_gnt;
  assign bus.rvalid = (r_count != '0);
  assign bus.rdata  = bus.rvalid ? r_fdata[r_rptr] : '0;
  assign bus.err    = bus.rvalid ? r_ferr[r_rptr]  : 1'b0;
  assign err_cnt_o  = r_err_cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wait_cnt <= '0;
    end else if (!bus.req || w_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != 4'(GNT_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_mem <= '0;
    end else if (w_acc && w_hit && bus.we) begin
      for (int b = 0; b < BW; b++)
        if (w_be_eff[b]) r_mem[w_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
    end
  end

  // Full FIFO refuses grant even when popping this cycle, so push never overruns.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_fdata   <= '0;
      r_ferr    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_fdata[r_wptr] <= w_push_data;
        r_ferr[r_wptr]  <= !w_hit;
        r_wptr          <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        if (r_ferr[r_rptr] && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_acc && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_acc && w_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_subordinate_mem.sv
// Directed bench: dut0 (GNT_WAIT=0) for data paths, dut2 (GNT_WAIT=2) for grant delay.
module tb_obi_subordinate_mem;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [7:0] err_cnt0, err_cnt2;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_t5;

  always #5 clk_i = ~clk_i;

  obi_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  obi_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

  obi_subordinate_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(16),
                        .GNT_WAIT(0), .RSP_DEPTH(2))
    dut0 (.clk_i(clk_i), .reset_ni(reset_ni), .bus(if0.slave), .err_cnt_o(err_cnt0));
  obi_subordinate_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(16),
                        .GNT_WAIT(2), .RSP_DEPTH(2))
    dut2 (.clk_i(clk_i), .reset_ni(reset_ni), .bus(if2.slave), .err_cnt_o(err_cnt2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  // Drive a request on dut0 mid-cycle, confirm gnt, then let the edge accept it.
  task automatic acc0(input string tag, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] be);
    if0.req = 1'b1; if0.addr = a; if0.we = w; if0.wdata = d; if0.be = be;
    #3 chk({tag, "_gnt"}, 64'(if0.gnt), 64'd1);
    nxt();
    if0.req = 1'b0;
  endtask

  initial begin
    if0.req = 0; if0.addr = 0; if0.we = 0; if0.be = 0; if0.wdata = 0; if0.rready = 1;
    if2.req = 0; if2.addr = 0; if2.we = 0; if2.be = 0; if2.wdata = 0; if2.rready = 1;

    // Reset state
    #3;
    chk("rst_gnt",    64'(if0.gnt),    64'd0);
    chk("rst_rvalid", 64'(if0.rvalid), 64'd0);
    chk("rst_rdata",  64'(if0.rdata),  64'd0);
    chk("rst_err",    64'(if0.err),    64'd0);
    chk("rst_errcnt", 64'(err_cnt0),   64'd0);
    nxt(); nxt();
    reset_ni = 1'b1;
    nxt();

    // T2: GNT_WAIT=2, req held from cycle 0
    if2.req = 1'b1; if2.addr = 32'h0;
    #3 chk("t2_gnt_c0", 64'(if2.gnt), 64'd0);
    nxt(); #3 chk("t2_gnt_c1", 64'(if2.gnt), 64'd0);
    nxt(); #3 chk("t2_gnt_c2", 64'(if2.gnt), 64'd1);
    chk("t2_rvalid_c2", 64'(if2.rvalid), 64'd0);
    nxt(); if2.req = 1'b0;
    chk("t2_rvalid_c3", 64'(if2.rvalid), 64'd1);
    nxt();
    // Withdrawn request: no response, and wait counter starts over
    if2.req = 1'b1; nxt(); if2.req = 1'b0;
    chk("t2_wd_rvalid", 64'(if2.rvalid), 64'd0);
    nxt();
    if2.req = 1'b1;
    #3 chk("t2_wd_gnt", 64'(if2.gnt), 64'd0);
    nxt(); if2.req = 1'b0;
    chk("t2_wd_rvalid2", 64'(if2.rvalid), 64'd0);

    // T1: write then read @0x8, GNT_WAIT=0
    #3 chk("t1_rvalid_pre", 64'(if0.rvalid), 64'd0);
    nxt();
    acc0("t1_wr", 32'h8, 1'b1, 32'hDEADBEEF, 4'hF);
    chk("t1_wr_rvalid", 64'(if0.rvalid), 64'd1);
    chk("t1_wr_err",    64'(if0.err),    64'd0);
    chk("t1_wr_rdata",  64'(if0.rdata),  64'd0);
    acc0("t1_rd", 32'h8, 1'b0, 32'h0, 4'h0);
    chk("t1_rd_rvalid", 64'(if0.rvalid), 64'd1);
    chk("t1_rd_rdata",  64'(if0.rdata),  64'hDEADBEEF);
    nxt();
    chk("t1_idle_rvalid", 64'(if0.rvalid), 64'd0);

    // T3: out-of-range read and misaligned write
    acc0("t3_rd", 32'h40, 1'b0, 32'h0, 4'h0);
    chk("t3_rd_err",   64'(if0.err),   64'd1);
    chk("t3_rd_rdata", 64'(if0.rdata), 64'd0);
    acc0("t3_wr", 32'h6, 1'b1, 32'hFFFFFFFF, 4'hF);
    chk("t3_wr_err",   64'(if0.err),   64'd1);
    chk("t3_wr_rdata", 64'(if0.rdata), 64'd0);
    nxt();
    chk("t3_errcnt", 64'(err_cnt0), 64'd2);
    acc0("t3_chk", 32'h4, 1'b0, 32'h0, 4'h0);
    chk("t3_mem_err",   64'(if0.err),   64'd0);
    chk("t3_mem_rdata", 64'(if0.rdata), 64'd0);
    nxt();

    // T5: byte-enabled partial write
`ifdef OBI_SBR_BE_EN
    exp_t5 = 32'hAABB11DD;
`else
    exp_t5 = 32'h00001100;
`endif
    acc0("t5_w1", 32'h0, 1'b1, 32'hAABBCCDD, 4'hF);
    acc0("t5_w2", 32'h0, 1'b1, 32'h00001100, 4'b0010);
    acc0("t5_rd", 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t5_rdata", 64'(if0.rdata), 64'(exp_t5));
    chk("t5_err",   64'(if0.err),   64'd0);
    nxt();

    // T4: FIFO full with rready low, no bypass on simultaneous pop
    if0.rready = 1'b0;
    acc0("t4_r0", 32'h0, 1'b0, 32'h0, 4'h0);
    acc0("t4_r1", 32'h8, 1'b0, 32'h0, 4'h0);
    if0.req = 1'b1; if0.addr = 32'h4; if0.we = 1'b0;
    #3 chk("t4_full_gnt", 64'(if0.gnt), 64'd0);
    chk("t4_head_rdata", 64'(if0.rdata), 64'(exp_t5));
    if0.rready = 1'b1;
    #1 chk("t4_full_pop_gnt", 64'(if0.gnt), 64'd0);
    nxt();
    #3 chk("t4_after_pop_gnt", 64'(if0.gnt), 64'd1);
    chk("t4_r1_rdata", 64'(if0.rdata), 64'hDEADBEEF);
    nxt(); if0.req = 1'b0;
    chk("t4_r2_rvalid", 64'(if0.rvalid), 64'd1);
    chk("t4_r2_rdata",  64'(if0.rdata),  64'd0);
    nxt();
    chk("t4_drain", 64'(if0.rvalid), 64'd0);

    // T6: async reset with two entries queued
    if0.rready = 1'b0;
    acc0("t6_r0", 32'h8, 1'b0, 32'h0, 4'h0);
    acc0("t6_r1", 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t6_pre_rvalid", 64'(if0.rvalid), 64'd1);
    #2 reset_ni = 1'b0;
    #1 chk("t6_rst_rvalid", 64'(if0.rvalid), 64'd0);
    chk("t6_rst_errcnt", 64'(err_cnt0), 64'd0);
    nxt(); nxt();
    reset_ni = 1'b1; if0.rready = 1'b1;
    nxt();
    acc0("t6_rd", 32'h8, 1'b0, 32'h0, 4'h0);
    chk("t6_rd_rvalid", 64'(if0.rvalid), 64'd1);
    chk("t6_rd_rdata",  64'(if0.rdata),  64'd0);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
